// File: rtl/scan_chain_ctrl.sv
// scan_chain_ctrl: serialises a parallel word into a register_cell chain, strobes update, reads back old contents
module scan_chain_ctrl #(
    parameter int CHAIN_LEN = 16,
    parameter int UPD_HOLD  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_i,
    input  logic [CHAIN_LEN-1:0] data_in_i,
    input  logic                 chain_ret_i,
    output logic                 chain_in_o,
    output logic                 enable_o,
    output logic                 update_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [CHAIN_LEN-1:0] rd_data_o
);
    localparam int MAXC = CHAIN_LEN > UPD_HOLD ? CHAIN_LEN : UPD_HOLD;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, UPDATE, FINISH} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [CHAIN_LEN-1:0] sh_q, sh_d, rd_q, rd_d, rd_data_q, rd_data_d;
    logic                 chain_in_q, chain_in_d, enable_q, enable_d;
    logic                 update_q, update_d, busy_q, busy_d, done_q, done_d;

    // state and registered outputs; reset never touches update, so cell outputs survive
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sh_q       <= '0;
            rd_q       <= '0;
            rd_data_q  <= '0;
            chain_in_q <= 1'b0;
            enable_q   <= 1'b0;
            update_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sh_q       <= sh_d;
            rd_q       <= rd_d;
            rd_data_q  <= rd_data_d;
            chain_in_q <= chain_in_d;
            enable_q   <= enable_d;
            update_q   <= update_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // sequencing: MSB first out, tail bits captured into rd while shifting
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sh_d       = sh_q;
        rd_d       = rd_q;
        rd_data_d  = rd_data_q;
        chain_in_d = chain_in_q;
        enable_d   = enable_q;
        update_d   = update_q;
        busy_d     = busy_q;
        done_d     = done_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d    = SHIFT;
                    sh_d       = data_in_i;
                    cnt_d      = '0;
                    enable_d   = 1'b1;
                    chain_in_d = data_in_i[CHAIN_LEN-1];
                    busy_d     = 1'b1;
                end
            end
            SHIFT: begin
                rd_d       = {rd_q[CHAIN_LEN-2:0], chain_ret_i};
                sh_d       = sh_q << 1;
                chain_in_d = sh_q[CHAIN_LEN-2];
                cnt_d      = cnt_q + CW'(1);
                if (cnt_q == CW'(CHAIN_LEN - 1)) begin
                    state_d    = UPDATE;
                    enable_d   = 1'b0;
                    update_d   = 1'b1;
                    chain_in_d = 1'b0;
                    cnt_d      = '0;
                end
            end
            UPDATE: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(UPD_HOLD - 1)) begin
                    state_d   = FINISH;
                    update_d  = 1'b0;
                    done_d    = 1'b1;
                    rd_data_d = rd_q;
                    cnt_d     = '0;
                end
            end
            FINISH: begin
                state_d = IDLE;
                done_d  = 1'b0;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    assign chain_in_o = chain_in_q;
    assign enable_o   = enable_q;
    assign update_o   = update_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign rd_data_o  = rd_data_q;
endmodule

// File: tb/tb_scan_chain_ctrl.sv
// tb_scan_chain_ctrl: three controller instances driving behavioural chains, scoreboarded on done
module tb_scan_chain_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0, ovl = 0, upd_cnt_a = 0;

    // instance A: CHAIN_LEN=16, UPD_HOLD=1
    logic rst_a = 1'b1, st_a = 1'b0, ret_a = 1'b0;
    logic [15:0] d_a = '0, rdd_a, q_a = '0, bo_a = '0;
    logic ci_a, en_a, up_a, bsy_a, dn_a;
    scan_chain_ctrl #(.CHAIN_LEN(16), .UPD_HOLD(1)) dut_a (
        .clk(clk), .reset(rst_a), .start_i(st_a), .data_in_i(d_a), .chain_ret_i(ret_a),
        .chain_in_o(ci_a), .enable_o(en_a), .update_o(up_a), .busy_o(bsy_a), .done_o(dn_a), .rd_data_o(rdd_a));

    // instance B: CHAIN_LEN=16, UPD_HOLD=3
    logic rst_b = 1'b1, st_b = 1'b0, ret_b = 1'b0;
    logic [15:0] d_b = '0, rdd_b, q_b = '0, bo_b = '0;
    logic ci_b, en_b, up_b, bsy_b, dn_b;
    scan_chain_ctrl #(.CHAIN_LEN(16), .UPD_HOLD(3)) dut_b (
        .clk(clk), .reset(rst_b), .start_i(st_b), .data_in_i(d_b), .chain_ret_i(ret_b),
        .chain_in_o(ci_b), .enable_o(en_b), .update_o(up_b), .busy_o(bsy_b), .done_o(dn_b), .rd_data_o(rdd_b));

    // instance C: CHAIN_LEN=2, UPD_HOLD=1
    logic rst_c = 1'b1, st_c = 1'b0, ret_c = 1'b0;
    logic [1:0] d_c = '0, rdd_c, q_c = '0, bo_c = '0;
    logic ci_c, en_c, up_c, bsy_c, dn_c;
    scan_chain_ctrl #(.CHAIN_LEN(2), .UPD_HOLD(1)) dut_c (
        .clk(clk), .reset(rst_c), .start_i(st_c), .data_in_i(d_c), .chain_ret_i(ret_c),
        .chain_in_o(ci_c), .enable_o(en_c), .update_o(up_c), .busy_o(bsy_c), .done_o(dn_c), .rd_data_o(rdd_c));

    // behavioural register_cell chains: capture on posedge when enabled, tail output moves on negedge
    always @(posedge clk) begin
        if (en_a) q_a <= {q_a[14:0], ci_a};
        if (up_a) bo_a <= q_a;
        if (en_b) q_b <= {q_b[14:0], ci_b};
        if (up_b) bo_b <= q_b;
        if (en_c) q_c <= {q_c[0], ci_c};
        if (up_c) bo_c <= q_c;
    end
    always @(negedge clk) begin
        ret_a <= q_a[15];
        ret_b <= q_b[15];
        ret_c <= q_c[1];
    end

    logic [31:0] sb_a[$], sb_b[$], sb_c[$];
    logic [31:0] e_a, e_b, e_c;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // scoreboard: each done pops {expected rd_data, expected bit_out}
    always @(negedge clk) begin
        if ((en_a & up_a) | (en_b & up_b) | (en_c & up_c)) ovl++;
        if (up_a) upd_cnt_a++;
        if (dn_a) begin
            chk("a_done_expected", 32'(sb_a.size() > 0), 32'd1);
            if (sb_a.size() > 0) begin
                e_a = sb_a.pop_front();
                chk("a_rd_data", 32'(rdd_a), {16'h0, e_a[31:16]});
                chk("a_bit_out", 32'(bo_a), {16'h0, e_a[15:0]});
            end
        end
        if (dn_b) begin
            chk("b_done_expected", 32'(sb_b.size() > 0), 32'd1);
            if (sb_b.size() > 0) begin
                e_b = sb_b.pop_front();
                chk("b_rd_data", 32'(rdd_b), {16'h0, e_b[31:16]});
                chk("b_bit_out", 32'(bo_b), {16'h0, e_b[15:0]});
            end
        end
        if (dn_c) begin
            chk("c_done_expected", 32'(sb_c.size() > 0), 32'd1);
            if (sb_c.size() > 0) begin
                e_c = sb_c.pop_front();
                chk("c_rd_data", 32'(rdd_c), {16'h0, e_c[31:16]});
                chk("c_bit_out", 32'(bo_c), {16'h0, e_c[15:0]});
            end
        end
    end

    int sel = 0;
    logic o_en, o_up, o_dn, o_bsy, o_ci;
    assign o_en  = sel == 0 ? en_a  : sel == 1 ? en_b  : en_c;
    assign o_up  = sel == 0 ? up_a  : sel == 1 ? up_b  : up_c;
    assign o_dn  = sel == 0 ? dn_a  : sel == 1 ? dn_b  : dn_c;
    assign o_bsy = sel == 0 ? bsy_a : sel == 1 ? bsy_b : bsy_c;
    assign o_ci  = sel == 0 ? ci_a  : sel == 1 ? ci_b  : ci_c;

    // caller has just passed edge 0; checks the output waveform through edge L+H+1
    task automatic trace(input string tag, input int L, input int H, input logic [15:0] d, input bit poke);
        int be = 0, bu = 0, bd = 0, bb = 0, bc = 0;
        for (int k = 0; k <= L + H + 1; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            if (poke && k == 5) begin
                st_a = 1'b1;
                d_a  = 16'hFFFF;
            end
            if (poke && k == 6) st_a = 1'b0;
            be += int'(o_en !== (k < L));
            bu += int'(o_up !== (k >= L && k < L + H));
            bd += int'(o_dn !== (k == L + H));
            bb += int'(o_bsy !== (k <= L + H));
            if (k < L) bc += int'(o_ci !== d[L-1-k]);
        end
        chk({tag, "_enable_window"}, be, 0);
        chk({tag, "_update_window"}, bu, 0);
        chk({tag, "_done_timing"}, bd, 0);
        chk({tag, "_busy_window"}, bb, 0);
        chk({tag, "_chain_in_bits"}, bc, 0);
    endtask

    int snap;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_flags", {27'h0, ci_a, en_a, up_a, bsy_a, dn_a}, 32'h0);
        chk("reset_rd_data", 32'(rdd_a), 32'h0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        rst_c = 1'b0;
        @(posedge clk);
        #1;

        // basic load
        sel = 0;
        st_a = 1'b1;
        d_a  = 16'hA5C3;
        sb_a.push_back({q_a, 16'hA5C3});
        @(posedge clk);
        #1;
        st_a = 1'b0;
        trace("basic", 16, 1, 16'hA5C3, 1'b0);
        chk("basic_bit_out", 32'(bo_a), 32'h0000A5C3);
        chk("basic_drained", sb_a.size(), 0);

        // read-back, with an ignored start pulse mid-load
        st_a = 1'b1;
        d_a  = 16'h1234;
        sb_a.push_back({q_a, 16'h1234});
        @(posedge clk);
        #1;
        st_a = 1'b0;
        trace("readback", 16, 1, 16'h1234, 1'b1);
        chk("readback_rd_data", 32'(rdd_a), 32'h0000A5C3);
        repeat (25) @(posedge clk);
        #1;
        chk("busy_start_ignored", sb_a.size(), 0);
        chk("busy_start_bit_out", 32'(bo_a), 32'h00001234);

        // reset mid-shift
        snap = upd_cnt_a;
        st_a = 1'b1;
        d_a  = 16'hFFFF;
        @(posedge clk);
        #1;
        st_a = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst_a = 1'b1;
        @(posedge clk);
        #1;
        rst_a = 1'b0;
        chk("midreset_flags", {27'h0, ci_a, en_a, up_a, bsy_a, dn_a}, 32'h0);
        chk("midreset_rd_data", 32'(rdd_a), 32'h0);
        repeat (25) @(posedge clk);
        #1;
        chk("midreset_no_update", upd_cnt_a - snap, 0);
        chk("midreset_bit_out", 32'(bo_a), 32'h00001234);

        // start coincident with reset
        st_a  = 1'b1;
        rst_a = 1'b1;
        @(posedge clk);
        #1;
        st_a  = 1'b0;
        rst_a = 1'b0;
        @(posedge clk);
        #1;
        chk("start_with_reset", {30'h0, bsy_a, en_a}, 32'h0);

        // clean load after the aborted one
        st_a = 1'b1;
        d_a  = 16'h00FF;
        sb_a.push_back({q_a, 16'h00FF});
        @(posedge clk);
        #1;
        st_a = 1'b0;
        trace("postreset", 16, 1, 16'h00FF, 1'b0);
        chk("postreset_bit_out", 32'(bo_a), 32'h000000FF);

        // UPD_HOLD=3 with start held high
        sel = 1;
        st_b = 1'b1;
        d_b  = 16'h5A5A;
        sb_b.push_back({q_b, 16'h5A5A});
        sb_b.push_back({16'h5A5A, 16'hC0DE});
        @(posedge clk);
        #1;
        d_b = 16'hC0DE;
        trace("b2b", 16, 3, 16'h5A5A, 1'b0);
        @(posedge clk);
        #1;
        chk("b2b_restart_at_21", {30'h0, en_b, bsy_b}, 32'h3);
        st_b = 1'b0;
        repeat (24) @(posedge clk);
        #1;
        chk("b2b_drained", sb_b.size(), 0);
        chk("b2b_bit_out", 32'(bo_b), 32'h0000C0DE);

        // width corner
        sel = 2;
        st_c = 1'b1;
        d_c  = 2'b10;
        sb_c.push_back({14'h0, q_c, 16'h0002});
        @(posedge clk);
        #1;
        st_c = 1'b0;
        trace("len2", 2, 1, 16'h0002, 1'b0);
        chk("len2_cells", 32'(bo_c), 32'h2);
        chk("len2_drained", sb_c.size(), 0);

        chk("enable_update_overlap", ovl, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/scan_chain_ctrl.md
# scan_chain_ctrl

Sequencer that loads a parallel configuration word into a daisy-chain of `register_cell` instances. It serialises the word onto `chain_in` with `enable` asserted for exactly `CHAIN_LEN` clock cycles, then pulses `update` so every cell transfers its shifted bit to `bit_out`. While shifting, it captures the bits returning from the chain tail, so the previous chain contents are available as a read-back word. It sits between the configuration host (register bank or SPI slave) and the chain.

## Interface
Parameters:
- `CHAIN_LEN`, default 16. Number of cells in the chain; ≥ 2.
- `UPD_HOLD`, default 1. Number of `clk` cycles `update` stays high; ≥ 1.

Ports:
- `clk`  in  1. Single clock; also drives the cells' `clk`.
- `reset`  in  1. Synchronous, active-high.
- `start`  in  1. Load request; sampled only in IDLE.
- `data_in`  in  `CHAIN_LEN`. Word to load; bit i ends in cell i (cell 0 is fed by `chain_in`).
- `chain_ret`  in  1. `chain_out` of cell `CHAIN_LEN-1`.
- `chain_in`  out  1. Serial data to cell 0.
- `enable`  out  1. Shift enable to all cells.
- `update`  out  1. Update strobe to all cells.
- `busy`  out  1. High whenever not IDLE.
- `done`  out  1. One-cycle completion pulse.
- `rd_data`  out  `CHAIN_LEN`. Chain contents before the last load; bit i is the old value of cell i.

## Operation
- FSM states: IDLE, SHIFT, UPDATE, FINISH. All outputs are driven directly from flops; there are no combinational paths from inputs to outputs.
- IDLE, when `start`=1:
  - capture `data_in` into shift register `sh`;
  - clear counter `cnt`;
  - go to SHIFT with `enable`<=1 and `chain_in`<=`data_in[CHAIN_LEN-1]`.
  - `data_in` is ignored at every other time.
- SHIFT, on each edge:
  - `rd` <= {`rd[CHAIN_LEN-2:0]`, `chain_ret`};
  - `sh` shifts left and `chain_in` presents the next MSB;
  - `cnt`++.
  - MSB is sent first, so `data_in[CHAIN_LEN-1]` travels to the last cell.
- At the edge where `cnt`==`CHAIN_LEN-1`, go to UPDATE: `enable`<=0, `update`<=1, `cnt`<=0. While `enable` is low the cells recirculate, so the chain is stable for update.
- UPDATE: hold `update` high for `UPD_HOLD` cycles. Then `update`<=0, `done`<=1, `rd_data`<=`rd`, go to FINISH.
- FINISH: `done`<=0, go to IDLE. `busy` deasserts on this edge.
- `start` outside IDLE is ignored; there is no queueing.
- `cnt` width is `$clog2(max(CHAIN_LEN, UPD_HOLD)+1)`. `cnt` never wraps: it is cleared on every state entry.

## Timing
- Reset (any state, including mid-SHIFT or mid-UPDATE) forces on the next edge:
  - state IDLE;
  - `enable`=0, `update`=0, `chain_in`=0, `busy`=0, `done`=0;
  - `rd_data`=0, `sh`=0, `cnt`=0.
- A reset mid-SHIFT leaves the chain partially shifted. Reset never issues `update`, so cell `bit_out` values are not corrupted.
- `start` is sampled at edge 0.
- `enable` is high for edges 1..`CHAIN_LEN`: exactly `CHAIN_LEN` cell capture edges.
- `update` rises after edge `CHAIN_LEN` and falls after edge `CHAIN_LEN+UPD_HOLD`.
- `done` is high for the cycle following edge `CHAIN_LEN+UPD_HOLD`.
- `busy` is high from after edge 0 through edge `CHAIN_LEN+UPD_HOLD+1`. Minimum start-to-start spacing is `CHAIN_LEN+UPD_HOLD+2` cycles.
- `enable` and `update` are never high in the same cycle.
- `chain_ret` is sampled on the same posedges at which cells capture. It must be stable, which is guaranteed because the cells update `chain_out` on the negedge.
- `start` held high continuously: a new load begins at the first IDLE edge.
- `start` coincident with `reset`: reset wins, and no load starts.

## Test plan
- **Basic load:** `CHAIN_LEN`=16, `UPD_HOLD`=1, behavioural 16-cell chain reset to 0; `start` with `data_in`=0xA5C3.
  - `enable` high exactly 16 cycles, then `update` high 1 cycle.
  - Cell `bit_out` = 0xA5C3.
  - `done` pulses at cycle 18; `rd_data`=0x0000.
- **Read-back:** a second load of 0x1234 after the basic load.
  - `rd_data`=0xA5C3; `bit_out`=0x1234.
- **Start while busy:** pulse `start` with 0xFFFF at cycle 5 of a load.
  - Ignored; exactly one `done` pulse; `bit_out` = original word.
- **Reset mid-shift:** assert `reset` at cycle 8.
  - Next edge: all outputs 0, `busy`=0, no `update` pulse ever issued.
  - `bit_out` keeps its prior value.
  - A following clean load of 0x00FF succeeds.
- **UPD_HOLD and back-to-back:** `UPD_HOLD`=3, `start` held high.
  - `update` is high for 3 cycles.
  - A new load starts every 21 cycles.
  - `enable`&`update` is never 1 in the same cycle.
- **Width corner:** `CHAIN_LEN`=2, `data_in`=2'b10.
  - Cell1=1, cell0=0; `done` at cycle 4.
